// File: rtl/rel_mem_accumulator.sv
// Spatial-unrolling reduction stage: sums the ROW x COL psum grid down to COL
// column sums per RF address and packs two addresses per GBF write word.
module rel_mem_accumulator #(
  parameter int ROW                   = 16,
  parameter int COL                   = 16,
  parameter int DATA_BITWIDTH         = 16,
  parameter int GBF_DATA_BITWIDTH     = 512,
  parameter int PSUM_RF_ADDR_BITWIDTH = 2,
  parameter int DEPTH                 = 32
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [DATA_BITWIDTH*ROW*COL-1:0]      psum_out,
  input  logic                                  pe_psum_finish,
  input  logic                                  conv_finish,
  output logic [PSUM_RF_ADDR_BITWIDTH-1:0]      psum_rf_addr,
  output logic                                  su_add_finish,
  output logic [GBF_DATA_BITWIDTH-1:0]          out_data,
  output logic                                  psum_gbf_w_en,
  output logic [$clog2(DEPTH)-1:0]              psum_gbf_w_addr,
  output logic                                  psum_gbf_w_num
);

  localparam int AW   = $clog2(DEPTH);
  localparam int HALF = COL * DATA_BITWIDTH;
  localparam logic [PSUM_RF_ADDR_BITWIDTH-1:0] LAST_ADDR = {PSUM_RF_ADDR_BITWIDTH{1'b1}};
  localparam logic [AW-1:0] LAST_WPTR = AW'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                   state_r;
  logic                     prev_r;
  logic                     pending_r;
  logic [AW-1:0]            wptr_r;
  logic [HALF-1:0]          lo_r;
  logic [HALF-1:0]          col_sums;
  logic [DATA_BITWIDTH-1:0] acc;
  logic                     start;

  assign start = pe_psum_finish & ~prev_r;

  // Column reduction over all rows, wrapping modulo 2^DATA_BITWIDTH.
  always_comb begin
    col_sums = {HALF{1'b0}};
    acc      = {DATA_BITWIDTH{1'b0}};
    for (int c = 0; c < COL; c++) begin
      acc = {DATA_BITWIDTH{1'b0}};
      for (int r = 0; r < ROW; r++) begin
        acc = acc + psum_out[(r*COL+c)*DATA_BITWIDTH +: DATA_BITWIDTH];
      end
      col_sums[c*DATA_BITWIDTH +: DATA_BITWIDTH] = acc;
    end
  end

  // Pass sequencing, word packing, write pointer and bank management.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r         <= IDLE;
      prev_r          <= 1'b0;
      pending_r       <= 1'b0;
      wptr_r          <= {AW{1'b0}};
      lo_r            <= {HALF{1'b0}};
      psum_rf_addr    <= {PSUM_RF_ADDR_BITWIDTH{1'b0}};
      su_add_finish   <= 1'b0;
      out_data        <= {GBF_DATA_BITWIDTH{1'b0}};
      psum_gbf_w_en   <= 1'b0;
      psum_gbf_w_addr <= {AW{1'b0}};
      psum_gbf_w_num  <= 1'b0;
    end else begin
      prev_r        <= pe_psum_finish;
      psum_gbf_w_en <= 1'b0;
      su_add_finish <= 1'b0;
      case (state_r)
        IDLE: begin
          psum_rf_addr <= {PSUM_RF_ADDR_BITWIDTH{1'b0}};
          // A pending bank swap lands before a coincident start is serviced.
          if (pending_r) begin
            wptr_r         <= {AW{1'b0}};
            psum_gbf_w_num <= ~psum_gbf_w_num;
          end else begin
            wptr_r         <= wptr_r;
          end
          pending_r <= conv_finish;
          if (start) begin
            state_r <= ADD;
          end else begin
            state_r <= IDLE;
          end
        end
        ADD: begin
          pending_r <= pending_r | conv_finish;
          if (!psum_rf_addr[0]) begin
            lo_r <= col_sums;
          end else begin
            out_data        <= {col_sums, lo_r};
            psum_gbf_w_en   <= 1'b1;
            psum_gbf_w_addr <= wptr_r;
            wptr_r          <= (wptr_r == LAST_WPTR) ? {AW{1'b0}} : wptr_r + AW'(1);
          end
          psum_rf_addr <= psum_rf_addr + PSUM_RF_ADDR_BITWIDTH'(1);
          if (psum_rf_addr == LAST_ADDR) begin
            state_r       <= DONE;
            su_add_finish <= 1'b1;
          end else begin
            state_r       <= ADD;
          end
        end
        DONE: begin
          pending_r <= pending_r | conv_finish;
          state_r   <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rel_mem_accumulator.sv
// Directed self-checking bench for rel_mem_accumulator at default parameters.
module tb_rel_mem_accumulator;

  logic          clk;
  logic          reset;
  logic [4095:0] psum_out;
  logic          pe_psum_finish;
  logic          conv_finish;
  logic [1:0]    psum_rf_addr;
  logic          su_add_finish;
  logic [511:0]  out_data;
  logic          psum_gbf_w_en;
  logic [4:0]    psum_gbf_w_addr;
  logic          psum_gbf_w_num;

  logic [4095:0] rf [4];
  int n_cmp;
  int n_fail;

  localparam logic [511:0] W72   = {32{16'd72}};
  localparam logic [511:0] WA0   = {{16{16'd32}}, {16{16'd16}}};
  localparam logic [511:0] WA1   = {{16{16'd64}}, {16{16'd48}}};
  localparam logic [511:0] WFULL = {32{16'hFFF0}};

  rel_mem_accumulator dut (
    .clk             (clk),
    .reset           (reset),
    .psum_out        (psum_out),
    .pe_psum_finish  (pe_psum_finish),
    .conv_finish     (conv_finish),
    .psum_rf_addr    (psum_rf_addr),
    .su_add_finish   (su_add_finish),
    .out_data        (out_data),
    .psum_gbf_w_en   (psum_gbf_w_en),
    .psum_gbf_w_addr (psum_gbf_w_addr),
    .psum_gbf_w_num  (psum_gbf_w_num)
  );

  assign psum_out = rf[psum_rf_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Group-structured grid: every column sums to 72 at every address.
  task automatic fill_72();
    int col15 [16] = '{1, 2, 2, 7, 3, 2, 4, 7, 5, 2, 6, 7, 7, 2, 8, 7};
    int oth [4] = '{3, 4, 5, 6};
    for (int a = 0; a < 4; a++)
      for (int r = 0; r < 16; r++)
        for (int c = 0; c < 16; c++)
          rf[a][(r*16+c)*16 +: 16] = (c == 15) ? 16'(col15[r]) : 16'(oth[r%4]);
  endtask

  task automatic fill_addr_plus_one();
    for (int a = 0; a < 4; a++)
      for (int e = 0; e < 256; e++)
        rf[a][e*16 +: 16] = 16'(a + 1);
  endtask

  task automatic fill_full();
    for (int a = 0; a < 4; a++) rf[a] = {4096{1'b1}};
  endtask

  // Raise pe_psum_finish at a negedge and check the five-cycle pass timeline.
  task automatic run_pass(input logic [511:0] w0, input logic [511:0] w1,
                          input logic [4:0] a0, input logic num, input int conv_at);
    pe_psum_finish = 1'b1;
    for (int k = 0; k <= 5; k++) begin
      conv_finish = (k == conv_at);
      @(negedge clk);
      check($sformatf("addr_k%0d", k), psum_rf_addr, (k < 4) ? 2'(k) : 2'd0);
      check($sformatf("wen_k%0d", k), psum_gbf_w_en, (k == 2 || k == 4) ? 1'b1 : 1'b0);
      check($sformatf("fin_k%0d", k), su_add_finish, (k == 4) ? 1'b1 : 1'b0);
      if (k == 2 || k == 3) begin
        check($sformatf("data0_k%0d", k), out_data, w0);
        check($sformatf("waddr0_k%0d", k), psum_gbf_w_addr, a0);
        check($sformatf("num0_k%0d", k), psum_gbf_w_num, num);
      end
      if (k == 4 || k == 5) begin
        check($sformatf("data1_k%0d", k), out_data, w1);
        check($sformatf("waddr1_k%0d", k), psum_gbf_w_addr, a0 + 5'd1);
        check($sformatf("num1_k%0d", k), psum_gbf_w_num, num);
      end
    end
    conv_finish = 1'b0;
  endtask

  task automatic release_level();
    pe_psum_finish = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    reset = 1'b1;
    pe_psum_finish = 1'b0;
    conv_finish = 1'b0;
    fill_72();
    repeat (3) @(negedge clk);
    check("rst_addr", psum_rf_addr, 2'd0);
    check("rst_fin", su_add_finish, 1'b0);
    check("rst_data", out_data, 512'd0);
    check("rst_wen", psum_gbf_w_en, 1'b0);
    check("rst_waddr", psum_gbf_w_addr, 5'd0);
    check("rst_num", psum_gbf_w_num, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_wen", psum_gbf_w_en, 1'b0);
      check("idle_fin", su_add_finish, 1'b0);
    end

    // Pass 1: constant 72 grid, level held high afterwards must not retrigger.
    run_pass(W72, W72, 5'd0, 1'b0, -1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("hold_wen", psum_gbf_w_en, 1'b0);
      check("hold_fin", su_add_finish, 1'b0);
      check("hold_addr", psum_rf_addr, 2'd0);
    end
    release_level();

    fill_addr_plus_one();
    run_pass(WA0, WA1, 5'd2, 1'b0, -1);
    release_level();

    fill_full();
    run_pass(WFULL, WFULL, 5'd4, 1'b0, -1);
    release_level();

    // Passes 4..16 fill addresses 6..31; pass 17 wraps to 0.
    fill_72();
    for (int p = 3; p < 16; p++) begin
      run_pass(W72, W72, 5'(2 * p), 1'b0, -1);
      release_level();
    end
    run_pass(W72, W72, 5'd0, 1'b0, -1);
    release_level();

    // conv_finish mid-pass: this pass stays on bank 0, next starts bank 1 at 0.
    run_pass(W72, W72, 5'd2, 1'b0, 2);
    release_level();
    run_pass(W72, W72, 5'd0, 1'b1, -1);
    release_level();

    // Pending swap coincides with start: applied first.
    conv_finish = 1'b1;
    @(negedge clk);
    conv_finish = 1'b0;
    run_pass(W72, W72, 5'd0, 1'b0, -1);
    release_level();

    // Reset mid-pass aborts without further writes.
    pe_psum_finish = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    pe_psum_finish = 1'b0;
    @(negedge clk);
    check("abort_wen", psum_gbf_w_en, 1'b0);
    check("abort_data", out_data, 512'd0);
    check("abort_addr", psum_rf_addr, 2'd0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("abort_idle_wen", psum_gbf_w_en, 1'b0);
    end
    fill_addr_plus_one();
    run_pass(WA0, WA1, 5'd0, 1'b0, -1);
    release_level();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
